// File: rtl/od_pkg.sv
// Shared types and default widths for the OD measurement-window datapath.
package od_pkg;

  localparam int OD_CNT_W = 10;
  localparam int OD_WIN_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    HOLD  = 2'd3
  } od_win_state_t;

endpackage

// File: rtl/od_sat_counter.sv
// Saturating up-counter with synchronous clear; sat_hit flags an increment lost at the ceiling.
import od_pkg::*;

module od_sat_counter #(
  parameter int N = OD_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [N-1:0] count,
  output logic         sat_hit
);

  localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};
  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

  // Event count register; holds at CNT_MAX instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= CNT_ZERO;
    end else if (clear) begin
      count <= CNT_ZERO;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

  assign sat_hit = enable & ~clear & (count == CNT_MAX);

endmodule

// File: rtl/od_window_ctrl.sv
// Measurement-window sequencer: counts event_in over a sampled window length and
// hands the final count, threshold hit and saturation flag over a valid/ready port.
import od_pkg::*;

module od_window_ctrl #(
  parameter int N     = OD_CNT_W,
  parameter int WIN_W = OD_WIN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [N-1:0]     threshold,
  input  logic             abort,
  input  logic             event_in,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [N-1:0]     result,
  output logic             hit,
  output logic             overflow
);

  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     CNT_MAX  = {N{1'b1}};
  localparam logic [N-1:0]     CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0]     CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

  od_win_state_t    state;
  od_win_state_t    state_next;
  logic [WIN_W-1:0] remaining;
  logic [WIN_W-1:0] win_eff;
  logic [N-1:0]     thr;
  logic [N-1:0]     count;
  logic             sat_hit;
  logic             last_cycle;

  // Value the counter will hold after this edge, used to register hit together with the final count.
  function automatic logic [N-1:0] sat_next(input logic [N-1:0] c, input logic ev);
    if (ev && (c != CNT_MAX)) begin
      sat_next = c + CNT_ONE;
    end else begin
      sat_next = c;
    end
  endfunction

  od_sat_counter #(.N(N)) u_event_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ARM),
    .enable  ((state == COUNT) & event_in),
    .count   (count),
    .sat_hit (sat_hit)
  );

  assign result     = count;
  assign last_cycle = (remaining == WIN_ONE);

  // Next-state decode; abort beats the final COUNT->HOLD step.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = ARM;
        else       state_next = IDLE;
      end
      ARM: begin
        if (abort) state_next = IDLE;
        else       state_next = COUNT;
      end
      COUNT: begin
        if (abort)           state_next = IDLE;
        else if (last_cycle) state_next = HOLD;
        else                 state_next = COUNT;
      end
      HOLD: begin
        if (result_ready) state_next = IDLE;
        else              state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, sampled parameters, window counter and result flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      remaining    <= WIN_ZERO;
      win_eff      <= WIN_ZERO;
      thr          <= CNT_ZERO;
      hit          <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_next;
      busy         <= (state_next != IDLE);
      result_valid <= (state_next == HOLD);
      case (state)
        IDLE: begin
          if (start) begin
            win_eff <= (win_len == WIN_ZERO) ? WIN_ONE : win_len;
            thr     <= threshold;
          end
        end
        ARM: begin
          remaining <= win_eff;
          hit       <= 1'b0;
          overflow  <= 1'b0;
        end
        COUNT: begin
          remaining <= remaining - WIN_ONE;
          if (sat_hit) overflow <= 1'b1;
          if (!abort && last_cycle) hit <= (sat_next(count, event_in) >= thr);
        end
        HOLD: begin
          remaining <= remaining;
        end
        default: begin
          remaining <= WIN_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_od_window_ctrl.sv
// Directed bench for od_window_ctrl: a default-width instance plus an N=4 instance for saturation.
`timescale 1ns/1ps

module tb_od_window_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        abort = 1'b0;
  logic        event_in = 1'b0;
  logic        result_ready = 1'b0;
  logic [15:0] win_len = 16'd0;
  logic [15:0] win_len4 = 16'd0;
  logic [9:0]  threshold = 10'd0;
  logic [3:0]  threshold4 = 4'd0;

  logic        busy, result_valid, hit, overflow;
  logic [9:0]  result;
  logic        busy4, valid4, hit4, overflow4;
  logic [3:0]  result4;

  int checks = 0;
  int errors = 0;

  od_window_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .win_len(win_len), .threshold(threshold),
    .abort(abort), .event_in(event_in), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .hit(hit), .overflow(overflow)
  );

  od_window_ctrl #(.N(4), .WIN_W(16)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .win_len(win_len4), .threshold(threshold4),
    .abort(abort), .event_in(event_in), .busy(busy4), .result_valid(valid4),
    .result_ready(result_ready), .result(result4), .hit(hit4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    checks++; if (result !== 10'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
    checks++; if (hit !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got hit=%b ovf=%b expected 0 0", hit, overflow); end
    checks++; if (busy4 !== 1'b0 || valid4 !== 1'b0 || result4 !== 4'd0) begin errors++; $display("FAIL reset_dut4: got busy=%b valid=%b result=%0d expected 0 0 0", busy4, valid4, result4); end
    reset = 1'b0;
    cyc();
  endtask

  // win_len=8, thr=3, 5 events in the window plus events in ARM and HOLD.
  task automatic test_basic();
    logic [7:0] pat;
    bit early;
    pat = 8'b1011_0101;
    early = 1'b0;
    win_len = 16'd8; threshold = 10'd3; start = 1'b1; event_in = 1'b1;
    cyc();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL basic_arm: got busy=%b valid=%b expected 1 0", busy, result_valid); end
    win_len = 16'd99; threshold = 10'd500;
    cyc();
    for (int i = 0; i < 8; i++) begin
      event_in = pat[i];
      if (result_valid) early = 1'b1;
      cyc();
    end
    // 9 edges after the start edge: first cycle of HOLD
    event_in = 1'b1;
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", early); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", result_valid); end
    checks++; if (result !== 10'd5) begin errors++; $display("FAIL basic_result: got %0d expected 5", result); end
    checks++; if (hit !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL basic_flags: got hit=%b ovf=%b expected 1 0", hit, overflow); end
    cyc();
    checks++; if (result !== 10'd5 || result_valid !== 1'b1) begin errors++; $display("FAIL basic_hold: got result=%0d valid=%b expected 5 1", result, result_valid); end
    result_ready = 1'b1;
    cyc();
    result_ready = 1'b0; event_in = 1'b0;
    checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_release: got valid=%b busy=%b expected 0 0", result_valid, busy); end
  endtask

  // N=4 instance, win_len=20 with event_in constantly high.
  task automatic test_saturation();
    int edges;
    bit found;
    bit wrap;
    logic [3:0] prev;
    edges = 0; found = 1'b0; wrap = 1'b0; prev = 4'd0;
    win_len4 = 16'd20; threshold4 = 4'd15; event_in = 1'b1; start4 = 1'b1;
    cyc();
    start4 = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (result4 < prev) wrap = 1'b1;
      prev = result4;
      if (valid4) found = 1'b1;
      else begin cyc(); edges++; end
    end
    checks++; if (!found || edges != 21) begin errors++; $display("FAIL sat_latency: got found=%b edges=%0d expected 1 21", found, edges); end
    checks++; if (result4 !== 4'd15) begin errors++; $display("FAIL sat_result: got %0d expected 15", result4); end
    checks++; if (overflow4 !== 1'b1 || hit4 !== 1'b1) begin errors++; $display("FAIL sat_flags: got ovf=%b hit=%b expected 1 1", overflow4, hit4); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL sat_wrap: got %b expected 0", wrap); end
    event_in = 1'b0; result_ready = 1'b1;
    cyc();
    result_ready = 1'b0;
    checks++; if (valid4 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL sat_release: got valid=%b busy=%b expected 0 0", valid4, busy4); end
  endtask

  // win_len=0 behaves as 1; win_len=1 with no events.
  task automatic test_short_windows();
    win_len = 16'd0; threshold = 10'd2; start = 1'b1;
    cyc();
    start = 1'b0; event_in = 1'b0;
    cyc();
    checks++; if (busy !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL w0_count_state: got busy=%b valid=%b expected 1 0", busy, result_valid); end
    event_in = 1'b1;
    cyc();
    event_in = 1'b0;
    checks++; if (result_valid !== 1'b1 || result !== 10'd1) begin errors++; $display("FAIL w0_result: got valid=%b result=%0d expected 1 1", result_valid, result); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL w0_hit: got %b expected 0", hit); end
    result_ready = 1'b1; cyc(); result_ready = 1'b0;
    win_len = 16'd1; threshold = 10'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    checks++; if (result_valid !== 1'b1 || result !== 10'd0 || hit !== 1'b0) begin errors++; $display("FAIL w1_result: got valid=%b result=%0d hit=%b expected 1 0 0", result_valid, result, hit); end
    result_ready = 1'b1; cyc(); result_ready = 1'b0;
  endtask

  // HOLD with result_ready low while start and event_in toggle.
  task automatic test_backpressure();
    win_len = 16'd2; threshold = 10'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    event_in = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0); event_in = ~event_in; threshold = 10'd1023;
      checks++; if (result_valid !== 1'b1 || result !== 10'd2) begin errors++; $display("FAIL bp_hold_%0d: got valid=%b result=%0d expected 1 2", i, result_valid, result); end
      cyc();
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL bp_hit: got %b expected 1", hit); end
    start = 1'b1; result_ready = 1'b1; event_in = 1'b0;
    cyc();
    start = 1'b0; result_ready = 1'b0;
    checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b busy=%b expected 0 0", result_valid, busy); end
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored: got busy=%b expected 0", busy); end
  endtask

  // abort on the last COUNT cycle of win_len=6, then a fresh run.
  task automatic test_abort();
    win_len = 16'd6; threshold = 10'd0; start = 1'b1;
    cyc();
    start = 1'b0; event_in = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0; event_in = 1'b0;
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b valid=%b expected 0 0", busy, result_valid); end
    cyc();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result: got %b expected 0", result_valid); end
    win_len = 16'd3; threshold = 10'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    checks++; if (result !== 10'd0 || overflow !== 1'b0) begin errors++; $display("FAIL abort_fresh: got result=%0d ovf=%b expected 0 0", result, overflow); end
    event_in = 1'b1; cyc();
    event_in = 1'b0; cyc();
    event_in = 1'b1; cyc();
    event_in = 1'b0;
    checks++; if (result_valid !== 1'b1 || result !== 10'd2 || hit !== 1'b1) begin errors++; $display("FAIL abort_rerun: got valid=%b result=%0d hit=%b expected 1 2 1", result_valid, result, hit); end
    result_ready = 1'b1; cyc(); result_ready = 1'b0;
  endtask

  // Asynchronous reset between edges mid-COUNT, then a normal run.
  task automatic test_reset_mid();
    win_len = 16'd10; threshold = 10'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    event_in = 1'b1;
    cyc(); cyc(); cyc();
    checks++; if (result !== 10'd3 || busy !== 1'b1) begin errors++; $display("FAIL rmid_pre: got result=%0d busy=%b expected 3 1", result, busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 10'd0 || hit !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL rmid_async: got busy=%b valid=%b result=%0d hit=%b ovf=%b expected all 0", busy, result_valid, result, hit, overflow);
    end
    event_in = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    win_len = 16'd4; threshold = 10'd4; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    event_in = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    event_in = 1'b0;
    checks++; if (result_valid !== 1'b1 || result !== 10'd4 || hit !== 1'b1) begin errors++; $display("FAIL rmid_rerun: got valid=%b result=%0d hit=%b expected 1 4 1", result_valid, result, hit); end
    result_ready = 1'b1; cyc(); result_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_short_windows();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
